uart_baud_tick_gen: RTL and testbench

Parametrised baud-rate tick generator for the UART receive and transmit paths. It replaces the fixed-count bit-rate toggler with four features: a runtime-programmable divisor, an oversampling sample tick, a one-cycle bit-boundary strobe, and a Restart input that re-phases the bit timing on a detected start-bit edge. It sits between SystemClock and the RX/TX bit state machines. The legacy toggling bit-rate output is kept for existing consumers.

---
 rtl/uart_baud_tick_gen.sv | 112 +++++++++++
 tb/tb_uart_baud_tick_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_tick_gen
//
// Baud-rate tick generator for the UART RX/TX bit state machines. A prescaler
// divides SystemClock by a runtime-programmable divisor to produce a one-cycle
// SampleTick. A sample counter then divides that by OVERSAMPLE to produce a
// one-cycle BitTick. NextBit is the legacy level output and toggles on every
// BitTick. Restart re-phases all counters, for example on a detected start-bit
// edge.
//
// Parameters:
//   DIV_W        width of Divisor and of the prescaler counter (>= 2)
//   OVERSAMPLE   sample ticks per bit (power of two, >= 4)
//   DEFAULT_DIV  divisor loaded at reset
//
// Ports:
//   SystemClock  in   system clock; everything is on the rising edge
//   ResetTimer   in   asynchronous active-high reset
//   Enable       in   1 = counters advance, 0 = counters hold
//   Restart      in   synchronous one-cycle re-phase request
//   Divisor      in   [DIV_W] clock cycles per sample tick (0 behaves as 1)
//   SampleTick   out  one-cycle pulse once per sample period
//   BitTick      out  one-cycle pulse once every OVERSAMPLE sample ticks
//   NextBit      out  toggles on every BitTick
//
// Build option:
//   UART_BAUD_MIDBIT_ALIGN_EN  when defined, Restart preloads the sample counter
//                              to OVERSAMPLE/2. The first BitTick then lands at
//                              the centre of the start bit (RX use). When it is
//                              not defined, BitTicks fall on bit boundaries
//                              (TX use).
// -----------------------------------------------------------------------------
module uart_baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 326
) (
  input  logic             SystemClock,
  input  logic             ResetTimer,
  input  logic             Enable,
  input  logic             Restart,
  input  logic [DIV_W-1:0] Divisor,
  output logic             SampleTick,
  output logic             BitTick,
  output logic             NextBit
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
`ifdef UART_BAUD_MIDBIT_ALIGN_EN
  localparam logic [OS_W-1:0]  OS_PRELOAD = OS_W'(OVERSAMPLE / 2);
`else
  localparam logic [OS_W-1:0]  OS_PRELOAD = '0;
`endif

  logic [DIV_W-1:0] divQ;      // active divisor, sampled from Divisor
  logic [DIV_W-1:0] preCnt;    // prescaler count within a sample period
  logic [OS_W-1:0]  osCnt;     // sample count within a bit
  logic [DIV_W-1:0] effDiv;
  logic [DIV_W-1:0] lastCnt;
  logic             sampleEvent;

  // A divisor of 0 behaves as 1, so preCnt always stays below effDiv and no
  // overflow path exists.
  assign effDiv      = (divQ == '0) ? DIV_ONE : divQ;
  assign lastCnt     = effDiv - DIV_ONE;
  assign sampleEvent = (preCnt == lastCnt);

  // Priority order: ResetTimer, then Restart, then Enable.
  // Divisor is sampled only on Restart or at the end of a sample period, so the
  // period in flight always completes at the old divisor.
  always_ff @(posedge SystemClock or posedge ResetTimer) begin
    if (ResetTimer) begin
      divQ       <= DIV_RESET;
      preCnt     <= '0;
      osCnt      <= '0;
      SampleTick <= 1'b0;
      BitTick    <= 1'b0;
      NextBit    <= 1'b0;
    end else if (Restart) begin
      divQ       <= Divisor;
      preCnt     <= '0;
      osCnt      <= OS_PRELOAD;
      SampleTick <= 1'b0;
      BitTick    <= 1'b0;
      NextBit    <= 1'b0;
    end else if (!Enable) begin
      SampleTick <= 1'b0;
      BitTick    <= 1'b0;
    end else if (sampleEvent) begin
      divQ       <= Divisor;
      preCnt     <= '0;
      SampleTick <= 1'b1;
      if (osCnt == OS_LAST) begin
        osCnt   <= '0;
        BitTick <= 1'b1;
        NextBit <= ~NextBit;
      end else begin
        osCnt   <= osCnt + 1'b1;
        BitTick <= 1'b0;
      end
    end else begin
      preCnt     <= preCnt + DIV_ONE;
      SampleTick <= 1'b0;
      BitTick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_tick_gen
//
// Directed bench for uart_baud_tick_gen with default parameters
// (OVERSAMPLE=16, DEFAULT_DIV=326). A vector table gives a divisor and a count
// of enabled edges after a Restart, together with the expected outputs. Hand-
// written sequences cover reset, a mid-period divisor change, an Enable gap and
// a Restart that collides with a BitTick.
// -----------------------------------------------------------------------------
module tb_uart_baud_tick_gen;

  // Number of sample ticks from a Restart to the first BitTick.
`ifdef UART_BAUD_MIDBIT_ALIGN_EN
  localparam int BIT_SAMPLES = 8;
`else
  localparam int BIT_SAMPLES = 16;
`endif

  logic        SystemClock;
  logic        ResetTimer;
  logic        Enable;
  logic        Restart;
  logic [15:0] Divisor;
  logic        SampleTick;
  logic        BitTick;
  logic        NextBit;

  int passCount  = 0;
  int totalCount = 0;

  uart_baud_tick_gen dut (
    .SystemClock (SystemClock),
    .ResetTimer  (ResetTimer),
    .Enable      (Enable),
    .Restart     (Restart),
    .Divisor     (Divisor),
    .SampleTick  (SampleTick),
    .BitTick     (BitTick),
    .NextBit     (NextBit)
  );

  initial SystemClock = 1'b0;
  always #5 SystemClock = ~SystemClock;

  typedef struct {
    logic [15:0] div;
    int          n;      // enabled edges after the Restart edge
    logic        expS;
    logic        expB;
    logic        expN;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic act, input logic exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Advance one edge, then move to a point 1 time unit after it for sampling/driving.
  task automatic step();
    @(posedge SystemClock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic restartWith(input logic [15:0] d);
    Divisor = d;
    Enable  = 1'b1;
    Restart = 1'b1;
    step();
    Restart = 1'b0;
  endtask

  initial begin
    // Vector table: the expectations are counted in edges from the Restart edge.
    // D=4: SampleTick at multiples of 4, BitTick at 4*BIT_SAMPLES and then every 64.
    vecs[0]  = '{16'd4, 3,                  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'd4, 4,                  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16'd4, 5,                  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'd4, 8,                  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{16'd4, 4*BIT_SAMPLES - 4,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'd4, 4*BIT_SAMPLES,      1'b1, 1'b1, 1'b1};
    vecs[6]  = '{16'd4, 4*BIT_SAMPLES + 1,  1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'd4, 4*BIT_SAMPLES + 63, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'd4, 4*BIT_SAMPLES + 64, 1'b1, 1'b1, 1'b0};
    // D=0 behaves as D=1: a SampleTick on every cycle, and a BitTick every 16.
    vecs[9]  = '{16'd0, 1,                  1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'd0, 2,                  1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'd0, BIT_SAMPLES,        1'b1, 1'b1, 1'b1};
    vecs[12] = '{16'd1, BIT_SAMPLES + 1,    1'b1, 1'b0, 1'b1};
    vecs[13] = '{16'd1, BIT_SAMPLES + 16,   1'b1, 1'b1, 1'b0};
    // Odd divisors
    vecs[14] = '{16'd7, 6,                  1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'd7, 7,                  1'b1, 1'b0, 1'b0};
    vecs[16] = '{16'd7, 14,                 1'b1, 1'b0, 1'b0};
    vecs[17] = '{16'd3, 3*BIT_SAMPLES,      1'b1, 1'b1, 1'b1};

    ResetTimer = 1'b1;
    Enable     = 1'b0;
    Restart    = 1'b0;
    Divisor    = 16'd4;
    steps(2);

    // Reset state
    check("reset_sample", SampleTick, 1'b0);
    check("reset_bit",    BitTick,    1'b0);
    check("reset_next",   NextBit,    1'b0);
    $display("reset state checked");

    // After release the default divisor (326) applies: the first SampleTick comes after edge 326.
    ResetTimer = 1'b0;
    Enable     = 1'b1;
    steps(325);
    check("default_div_325", SampleTick, 1'b0);
    step();
    check("default_div_326", SampleTick, 1'b1);
    $display("default divisor first tick checked");

    // Drive the outputs active, then reset asynchronously in mid-cycle.
    restartWith(16'd1);
    steps(BIT_SAMPLES);
    check("pre_async_sample", SampleTick, 1'b1);
    check("pre_async_bit",    BitTick,    1'b1);
    check("pre_async_next",   NextBit,    1'b1);
    #2 ResetTimer = 1'b1;
    #1;
    check("async_sample", SampleTick, 1'b0);
    check("async_bit",    BitTick,    1'b0);
    check("async_next",   NextBit,    1'b0);
    step();
    ResetTimer = 1'b0;
    $display("async reset mid-pulse checked");

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      restartWith(vecs[v].div);
      check("restart_sample", SampleTick, 1'b0);
      steps(vecs[v].n);
      check("vec_sample", SampleTick, vecs[v].expS);
      check("vec_bit",    BitTick,    vecs[v].expB);
      check("vec_next",   NextBit,    vecs[v].expN);
      $display("vec %0d div=%0d n=%0d S=%b B=%b N=%b", v, vecs[v].div, vecs[v].n,
               SampleTick, BitTick, NextBit);
    end

    // Divisor changes from 4 to 8 at the 2nd cycle of the second period.
    restartWith(16'd4);
    steps(5);
    Divisor = 16'd8;
    steps(2);
    check("divchg_7", SampleTick, 1'b0);
    step();
    check("divchg_8", SampleTick, 1'b1);
    steps(7);
    check("divchg_15", SampleTick, 1'b0);
    step();
    check("divchg_16", SampleTick, 1'b1);
    steps(8);
    check("divchg_24", SampleTick, 1'b1);
    $display("divisor change mid-period checked");

    // Enable gap of 10 cycles in mid-bit: the BitTick moves 10 cycles later.
    restartWith(16'd4);
    steps(20);
    check("gap_pre_sample", SampleTick, 1'b1);
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("gap_sample", SampleTick, 1'b0);
      check("gap_bit",    BitTick,    1'b0);
      check("gap_next",   NextBit,    1'b0);
    end
    Enable = 1'b1;
    steps(4*BIT_SAMPLES - 20 - 1);
    check("gap_bit_early", BitTick, 1'b0);
    step();
    check("gap_bit_late",  BitTick, 1'b1);
    check("gap_next_tgl",  NextBit, 1'b1);
    $display("enable gap checked");

    // Restart collides with a BitTick while NextBit=1 (second bit).
    restartWith(16'd4);
    steps(4*BIT_SAMPLES + 63);
    check("coll_pre_next", NextBit, 1'b1);
    Restart = 1'b1;
    step();
    Restart = 1'b0;
    check("coll_sample", SampleTick, 1'b0);
    check("coll_bit",    BitTick,    1'b0);
    check("coll_next",   NextBit,    1'b0);
    steps(3);
    check("coll_s3", SampleTick, 1'b0);
    step();
    check("coll_s4", SampleTick, 1'b1);
    steps(4*BIT_SAMPLES - 4);
    check("coll_bit_after",  BitTick, 1'b1);
    check("coll_next_after", NextBit, 1'b1);
    $display("restart on bit tick checked");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
